// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences the shared memory/ALU datapath over 3-5 cycles per
// instruction, with memory states stretched on mem_ready.
module multicycle_control #(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic [3:0] ALUCtrl,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal,
   output logic       halted,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_NOR = 4'b1010;

   localparam state_t S_ILLEGAL_NEXT = ILLEGAL_TRAP ? S_HALT : S_FETCH;

   state_t     state_q;
   state_t     state_d;

   logic       pc_write;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       done;
   logic       ill;
   logic       hlt;

   logic [3:0] funct_alu;
   logic       funct_ok;
   logic [3:0] imm_alu;
   logic       imm_zext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // R-type function decode, shared by EXEC and ALUWB
   always_comb begin
      funct_alu = ALU_ADD;
      funct_ok  = 1'b1;
      case (Funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b100110: funct_alu = ALU_XOR;
         6'b100111: funct_alu = ALU_NOR;
         6'b101010: funct_alu = ALU_SLT;
         6'b000000: funct_alu = ALU_SLL;
         6'b000010: funct_alu = ALU_SRL;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Immediate-form decode, shared by IEXEC and IWB
   always_comb begin
      imm_alu  = ALU_ADD;
      imm_zext = 1'b0;
      case (Opcode)
         OP_ANDI: begin imm_alu = ALU_AND; imm_zext = 1'b1; end
         OP_ORI:  begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
         OP_XORI: begin imm_alu = ALU_XOR; imm_zext = 1'b1; end
         default: begin imm_alu = ALU_ADD; imm_zext = 1'b0; end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_write  = 1'b0;
      IorD      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      reg_write = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ZeroExt   = 1'b0;
      ALUCtrl   = ALU_ADD;
      PCSource  = 2'b00;
      done      = 1'b0;
      ill       = 1'b0;
      hlt       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            ALUSrcB  = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (Opcode)
               OP_LW, OP_SW:                      state_d = S_MEMADR;
               OP_RTYPE:                          state_d = S_EXEC;
               OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
               OP_J:                              state_d = S_JUMP;
               default: begin
                  ill     = 1'b1;
                  state_d = S_ILLEGAL_NEXT;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (Opcode == OP_LW) begin
               state_d = S_MEMRD;
            end else if (Opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMRD: begin
            IorD     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            MemtoReg  = 1'b1;
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               done    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            if (funct_ok) begin
               ALUCtrl = funct_alu;
               state_d = S_ALUWB;
            end else begin
               ill     = 1'b1;
               state_d = S_ILLEGAL_NEXT;
            end
         end
         S_ALUWB: begin
            RegDst    = 1'b1;
            reg_write = 1'b1;
            ALUCtrl   = funct_alu;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            // A-B through the ALU drives Zero; target was precomputed into ALUOut in DECODE
            ALUSrcA  = 1'b1;
            ALUCtrl  = ALU_SUB;
            PCSource = 2'b01;
            pc_write = ((Opcode == OP_BEQ) & Zero) | ((Opcode == OP_BNE) & ~Zero);
            done     = 1'b1;
            state_d  = S_FETCH;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUCtrl = imm_alu;
            ZeroExt = imm_zext;
            state_d = S_IWB;
         end
         S_IWB: begin
            reg_write = 1'b1;
            ALUCtrl   = imm_alu;
            ZeroExt   = imm_zext;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            PCSource = 2'b10;
            pc_write = 1'b1;
            done     = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT: begin
            hlt     = 1'b1;
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset gates every write enable and pulse combinationally so an abort takes effect at once
   assign PCWrite    = pc_write  & ~rst;
   assign MemRead    = mem_read  & ~rst;
   assign MemWrite   = mem_write & ~rst;
   assign IRWrite    = ir_write  & ~rst;
   assign RegWrite   = reg_write & ~rst;
   assign instr_done = done      & ~rst;
   assign illegal    = ill       & ~rst;
   assign halted     = hlt       & ~rst;
   assign state      = state_q;

endmodule
